usrt_frame_ctrl: RTL and testbench

- APB-facing controller that sequences the USRT datapath: one baud-tick generator, one TX frame FSM, one RX frame FSM, and the holding/status registers between the bus and the line.
- Replaces ad-hoc enable decoding with a single register map and explicit frame state machines.
- Sits between the APB bus (pClk domain) and the serial pins txd/rxd.
- uClk is exported as the frame-bit strobe.

---
 rtl/usrt_pkg.sv | 39 +++
 rtl/usrt_frame_ctrl_if.sv | 21 ++
 rtl/usrt_baud_tick.sv | 37 +++
 rtl/usrt_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_usrt_frame_ctrl.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usrt_pkg.sv
// Shared constants for the USRT frame controller: register map, bit
// positions, frame geometry and frame state machine encodings.
package usrt_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_STAT = 2'd1;
  localparam logic [1:0] ADDR_CTRL = 2'd2;
  localparam logic [1:0] ADDR_DIV  = 2'd3;

  localparam int unsigned ST_TX_FULL  = 0;
  localparam int unsigned ST_RX_VALID = 1;
  localparam int unsigned ST_TX_BUSY  = 2;
  localparam int unsigned ST_PAR_ERR  = 3;
  localparam int unsigned ST_STOP_ERR = 4;
  localparam int unsigned ST_OVR      = 5;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_IRQ_TX = 1;
  localparam int unsigned CTRL_IRQ_RX = 2;

  localparam int unsigned FRAME_DATA_BITS = 8;
  localparam int unsigned BIT_CNT_W       = $clog2(FRAME_DATA_BITS);

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/usrt_frame_ctrl_if.sv
// APB-side signal bundle of the USRT frame controller.
interface usrt_frame_ctrl_if;
  logic       pSel;
  logic       pEnable;
  logic       pWrite;
  logic [1:0] pAddr;
  logic [7:0] pWData;
  logic [7:0] pRData;
  logic       pReady;
  logic       pSlverr;

  modport master (
    output pSel, pEnable, pWrite, pAddr, pWData,
    input  pRData, pReady, pSlverr
  );

  modport slave (
    input  pSel, pEnable, pWrite, pAddr, pWData,
    output pRData, pReady, pSlverr
  );
endinterface

// File: rtl/usrt_baud_tick.sv
// Baud tick generator: counts 0..div and emits a one-cycle uClk strobe on wrap.
module usrt_baud_tick #(
  parameter int unsigned DIV_W = 8
) (
  input  logic             pClk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             uClk
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             tick;

  // Next count: cleared on request or while disabled, wraps at div.
  always_comb begin
    tick  = en && (cnt_q == div);
    cnt_d = cnt_q;
    if (clr || !en) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge pClk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign uClk = tick;

endmodule

// File: rtl/usrt_frame_ctrl.sv
// USRT frame controller: APB register file, TX/RX frame FSMs and baud tick.
// Frame: start=1, 8 data bits LSB first, even-XOR parity, stop=0; idle line 0.
module usrt_frame_ctrl
  import usrt_pkg::*;
#(
  parameter int unsigned DIV_DEFAULT = 79,
  parameter int unsigned DIV_W       = 8
) (
  input  logic               pClk,
  input  logic               rst,
  usrt_frame_ctrl_if.slave   apb,
  input  logic               rxd,
  output logic               txd,
  output logic               uClk,
  output logic               irq
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_DATA_BITS - 1);

  logic [2:0]           ctrl_q, ctrl_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [7:0]           tx_hold_q, tx_hold_d;
  logic                 tx_full_q, tx_full_d;
  logic [7:0]           rx_hold_q, rx_hold_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 par_err_q, par_err_d;
  logic                 stop_err_q, stop_err_d;
  logic                 ovr_q, ovr_d;

  tx_state_t            tx_state_q, tx_state_d;
  logic [7:0]           tx_sh_q, tx_sh_d;
  logic [BIT_CNT_W-1:0] tx_cnt_q, tx_cnt_d;
  logic                 tx_par_q, tx_par_d;
  logic                 txd_q, txd_d;
  logic                 tx_load;

  rx_state_t            rx_state_q, rx_state_d;
  logic [7:0]           rx_sh_q, rx_sh_d;
  logic [BIT_CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic                 rx_par_bad_q, rx_par_bad_d;
  logic                 rx_good, rx_par_fail, rx_stop_fail;

  logic access, wr_data, wr_stat, wr_ctrl, wr_div, rd_data;
  logic tx_accept, rx_pop, en_next, tx_busy;
  logic [7:0] status;

  assign access    = apb.pSel & apb.pEnable;
  assign wr_data   = access &  apb.pWrite & (apb.pAddr == ADDR_DATA);
  assign wr_stat   = access &  apb.pWrite & (apb.pAddr == ADDR_STAT);
  assign wr_ctrl   = access &  apb.pWrite & (apb.pAddr == ADDR_CTRL);
  assign wr_div    = access &  apb.pWrite & (apb.pAddr == ADDR_DIV);
  assign rd_data   = access & ~apb.pWrite & (apb.pAddr == ADDR_DATA);
  assign tx_accept = wr_data & ~tx_full_q;
  assign rx_pop    = rd_data & rx_valid_q;
  assign tx_busy   = (tx_state_q != TX_IDLE);

  // FSMs follow the enable value being committed this edge, so clearing en
  // idles both frames on the same edge as the CTRL write.
  assign en_next   = ctrl_d[CTRL_EN];

  usrt_baud_tick #(.DIV_W(DIV_W)) u_baud (
    .pClk (pClk),
    .rst  (rst),
    .en   (ctrl_q[CTRL_EN]),
    .clr  (wr_div | ~en_next),
    .div  (div_q),
    .uClk (uClk)
  );

  // Configuration registers: CTRL and DIV.
  always_comb begin
    ctrl_d = ctrl_q;
    div_d  = div_q;
    if (wr_ctrl) ctrl_d = apb.pWData[2:0];
    if (wr_div)  div_d  = DIV_W'(apb.pWData);
  end

  // TX frame FSM: next state, shift register and registered line value.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_sh_d    = tx_sh_q;
    tx_cnt_d   = tx_cnt_q;
    tx_par_d   = tx_par_q;
    txd_d      = txd_q;
    tx_load    = 1'b0;
    if (!en_next) begin
      tx_state_d = TX_IDLE;
      txd_d      = 1'b0;
    end else if (uClk) begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_full_q) begin
            tx_load    = 1'b1;
            tx_state_d = TX_START;
            tx_sh_d    = tx_hold_q;
            tx_par_d   = ^tx_hold_q;
            txd_d      = 1'b1;
          end
        end
        TX_START: begin
          tx_state_d = TX_DATA;
          txd_d      = tx_sh_q[0];
          tx_sh_d    = tx_sh_q >> 1;
          tx_cnt_d   = '0;
        end
        TX_DATA: begin
          if (tx_cnt_q == LAST_BIT) begin
            tx_state_d = TX_PARITY;
            txd_d      = tx_par_q;
          end else begin
            txd_d    = tx_sh_q[0];
            tx_sh_d  = tx_sh_q >> 1;
            tx_cnt_d = tx_cnt_q + BIT_CNT_W'(1);
          end
        end
        TX_PARITY: begin
          tx_state_d = TX_STOP;
          txd_d      = 1'b0;
        end
        TX_STOP: begin
          if (tx_full_q) begin
            tx_load    = 1'b1;
            tx_state_d = TX_START;
            tx_sh_d    = tx_hold_q;
            tx_par_d   = ^tx_hold_q;
            txd_d      = 1'b1;
          end else begin
            tx_state_d = TX_IDLE;
            txd_d      = 1'b0;
          end
        end
        default: begin
          tx_state_d = TX_IDLE;
          txd_d      = 1'b0;
        end
      endcase
    end
  end

  // RX frame FSM: samples rxd on each tick and reports frame outcome.
  always_comb begin
    rx_state_d   = rx_state_q;
    rx_sh_d      = rx_sh_q;
    rx_cnt_d     = rx_cnt_q;
    rx_par_bad_d = rx_par_bad_q;
    rx_good      = 1'b0;
    rx_par_fail  = 1'b0;
    rx_stop_fail = 1'b0;
    if (!en_next) begin
      rx_state_d = RX_IDLE;
    end else if (uClk) begin
      case (rx_state_q)
        RX_IDLE: begin
          if (rxd) begin
            rx_state_d = RX_DATA;
            rx_cnt_d   = '0;
          end
        end
        RX_DATA: begin
          rx_sh_d = {rxd, rx_sh_q[7:1]};
          if (rx_cnt_q == LAST_BIT) rx_state_d = RX_PARITY;
          else                      rx_cnt_d   = rx_cnt_q + BIT_CNT_W'(1);
        end
        RX_PARITY: begin
          rx_par_bad_d = rxd ^ (^rx_sh_q);
          rx_state_d   = RX_STOP;
        end
        RX_STOP: begin
          rx_par_fail  = rx_par_bad_q;
          rx_stop_fail = rxd;
          rx_good      = ~rx_par_bad_q & ~rxd;
          rx_state_d   = RX_IDLE;
        end
        default: rx_state_d = RX_IDLE;
      endcase
    end
  end

  // Holding registers and status flags; a frame load beats a same-edge pop.
  always_comb begin
    tx_hold_d  = tx_hold_q;
    tx_full_d  = tx_full_q;
    rx_hold_d  = rx_hold_q;
    rx_valid_d = rx_valid_q;
    par_err_d  = par_err_q;
    stop_err_d = stop_err_q;
    ovr_d      = ovr_q;
    if (tx_load) tx_full_d = 1'b0;
    if (tx_accept) begin
      tx_hold_d = apb.pWData;
      tx_full_d = 1'b1;
    end
    if (rx_pop) rx_valid_d = 1'b0;
    if (wr_stat) begin
      if (apb.pWData[ST_PAR_ERR])  par_err_d  = 1'b0;
      if (apb.pWData[ST_STOP_ERR]) stop_err_d = 1'b0;
      if (apb.pWData[ST_OVR])      ovr_d      = 1'b0;
    end
    if (rx_par_fail)  par_err_d  = 1'b1;
    if (rx_stop_fail) stop_err_d = 1'b1;
    if (rx_good) begin
      if (rx_valid_q && !rx_pop) begin
        ovr_d = 1'b1;
      end else begin
        rx_hold_d  = rx_sh_q;
        rx_valid_d = 1'b1;
      end
    end
  end

  // APB response: zero-wait ready, read mux and error flag.
  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = tx_full_q;
    status[ST_RX_VALID]   = rx_valid_q;
    status[ST_TX_BUSY]    = tx_busy;
    status[ST_PAR_ERR]    = par_err_q;
    status[ST_STOP_ERR]   = stop_err_q;
    status[ST_OVR]        = ovr_q;
    apb.pReady  = access;
    apb.pSlverr = (wr_data & tx_full_q) | (rd_data & ~rx_valid_q);
    apb.pRData  = '0;
    if (access) begin
      case (apb.pAddr)
        ADDR_DATA: apb.pRData = rx_valid_q ? rx_hold_q : 8'h00;
        ADDR_STAT: apb.pRData = status;
        ADDR_CTRL: apb.pRData = {5'b00000, ctrl_q};
        default:   apb.pRData = 8'(div_q);
      endcase
    end
  end

  // State registers.
  always_ff @(posedge pClk) begin
    if (rst) begin
      ctrl_q       <= '0;
      div_q        <= DIV_W'(DIV_DEFAULT);
      tx_hold_q    <= '0;
      tx_full_q    <= 1'b0;
      rx_hold_q    <= '0;
      rx_valid_q   <= 1'b0;
      par_err_q    <= 1'b0;
      stop_err_q   <= 1'b0;
      ovr_q        <= 1'b0;
      tx_state_q   <= TX_IDLE;
      tx_sh_q      <= '0;
      tx_cnt_q     <= '0;
      tx_par_q     <= 1'b0;
      txd_q        <= 1'b0;
      rx_state_q   <= RX_IDLE;
      rx_sh_q      <= '0;
      rx_cnt_q     <= '0;
      rx_par_bad_q <= 1'b0;
    end else begin
      ctrl_q       <= ctrl_d;
      div_q        <= div_d;
      tx_hold_q    <= tx_hold_d;
      tx_full_q    <= tx_full_d;
      rx_hold_q    <= rx_hold_d;
      rx_valid_q   <= rx_valid_d;
      par_err_q    <= par_err_d;
      stop_err_q   <= stop_err_d;
      ovr_q        <= ovr_d;
      tx_state_q   <= tx_state_d;
      tx_sh_q      <= tx_sh_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_par_q     <= tx_par_d;
      txd_q        <= txd_d;
      rx_state_q   <= rx_state_d;
      rx_sh_q      <= rx_sh_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_par_bad_q <= rx_par_bad_d;
    end
  end

  assign txd = txd_q;
  assign irq = (ctrl_q[CTRL_IRQ_RX] & (rx_valid_q | par_err_q | stop_err_q | ovr_q))
             | (ctrl_q[CTRL_IRQ_TX] & ctrl_q[CTRL_EN] & ~tx_full_q);

endmodule

// File: tb/tb_usrt_frame_ctrl.sv
// Scoreboard bench for usrt_frame_ctrl: APB responses and txd bits are
// queued as expectations and checked by independent monitors.
module tb_usrt_frame_ctrl;
  import usrt_pkg::*;

  logic pClk = 1'b0;
  logic rst  = 1'b1;
  logic rxd  = 1'b0;
  logic txd, uClk, irq;

  usrt_frame_ctrl_if apb ();

  usrt_frame_ctrl #(.DIV_DEFAULT(79), .DIV_W(8)) dut (
    .pClk (pClk),
    .rst  (rst),
    .apb  (apb),
    .rxd  (rxd),
    .txd  (txd),
    .uClk (uClk),
    .irq  (irq)
  );

  always #5 pClk = ~pClk;

  typedef struct packed {
    logic       chk_data;
    logic [7:0] data;
    logic       slverr;
  } apb_exp_t;

  apb_exp_t apb_q[$];
  string    apb_name_q[$];
  logic     tx_q[$];
  int       n_cmp = 0;
  int       n_err = 0;
  logic     tick_seen = 1'b0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // APB monitor: every access phase consumes one queued expectation.
  always @(negedge pClk) begin
    apb_exp_t e;
    string    nm;
    if (!rst && apb.pSel && apb.pEnable) begin
      if (apb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL apb_unexpected: access with no expectation at %0t", $time);
      end else begin
        e  = apb_q.pop_front();
        nm = apb_name_q.pop_front();
        check({nm, "_ready"}, 32'(apb.pReady), 32'd1);
        if (e.chk_data) check({nm, "_rdata"}, 32'(apb.pRData), 32'(e.data));
        check({nm, "_slverr"}, 32'(apb.pSlverr), 32'(e.slverr));
      end
    end
  end

  // Line monitor: after each tick edge txd must match the next queued bit, or idle 0.
  always @(negedge pClk) begin
    if (rst) begin
      tick_seen <= 1'b0;
    end else begin
      if (tick_seen) begin
        if (tx_q.size() > 0) check("txd_bit", 32'(txd), 32'(tx_q.pop_front()));
        else                 check("txd_idle", 32'(txd), 32'd0);
      end
      tick_seen <= uClk;
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic apb_write(input logic [1:0] a, input logic [7:0] d, input logic exp_err, input string name);
    apb_exp_t e;
    e.chk_data = 1'b0;
    e.data     = 8'h00;
    e.slverr   = exp_err;
    apb_q.push_back(e);
    apb_name_q.push_back(name);
    apb.pSel = 1'b1; apb.pWrite = 1'b1; apb.pAddr = a; apb.pWData = d; apb.pEnable = 1'b0;
    @(posedge pClk); #1 apb.pEnable = 1'b1;
    @(posedge pClk); #1 apb.pSel = 1'b0; apb.pEnable = 1'b0; apb.pWrite = 1'b0;
  endtask

  task automatic apb_read(input logic [1:0] a, input logic [7:0] exp_d, input logic exp_err, input string name);
    apb_exp_t e;
    e.chk_data = 1'b1;
    e.data     = exp_d;
    e.slverr   = exp_err;
    apb_q.push_back(e);
    apb_name_q.push_back(name);
    apb.pSel = 1'b1; apb.pWrite = 1'b0; apb.pAddr = a; apb.pEnable = 1'b0;
    @(posedge pClk); #1 apb.pEnable = 1'b1;
    @(posedge pClk); #1 apb.pSel = 1'b0; apb.pEnable = 1'b0;
  endtask

  // Returns 1ns after the next posedge on which uClk was high.
  task automatic sync_tick();
    int n = 0;
    @(negedge pClk);
    while (!uClk && n < 300) begin
      @(negedge pClk);
      n++;
    end
    if (!uClk) begin
      n_cmp++;
      n_err++;
      $display("FAIL tick_timeout: no uClk within %0d cycles at %0t", n, $time);
    end
    @(posedge pClk); #1;
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) sync_tick();
  endtask

  task automatic cycles_to_tick(input int exp, input string name);
    int n = 0;
    do begin
      @(negedge pClk);
      n++;
    end while (!uClk && n < 300);
    check(name, 32'(n), 32'(exp));
    @(posedge pClk); #1;
  endtask

  // Frame bits are pushed start first: f[0]=start, f[8:1]=data, f[9]=parity, f[10]=stop.
  task automatic push_frame(input logic [10:0] f);
    for (int i = 0; i < 11; i++) tx_q.push_back(f[i]);
  endtask

  task automatic send_rx(input logic [10:0] f);
    sync_tick();
    for (int i = 0; i < 11; i++) begin
      rxd = f[i];
      sync_tick();
    end
    rxd = 1'b0;
  endtask

  initial begin
    apb.pSel = 1'b0; apb.pEnable = 1'b0; apb.pWrite = 1'b0; apb.pAddr = 2'd0; apb.pWData = 8'h00;
    repeat (3) @(posedge pClk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_txd", 32'(txd), 32'd0);
    check("rst_uclk", 32'(uClk), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_pready", 32'(apb.pReady), 32'd0);
    check("rst_prdata", 32'(apb.pRData), 32'd0);
    apb_read(ADDR_DATA, 8'h00, 1'b1, "rst_data");
    apb_read(ADDR_STAT, 8'h00, 1'b0, "rst_stat");
    apb_read(ADDR_CTRL, 8'h00, 1'b0, "rst_ctrl");
    apb_read(ADDR_DIV,  8'd79, 1'b0, "rst_div");

    // Enable, let the counter run, then a DIV write restarts it from 0
    apb_write(ADDR_CTRL, 8'h01, 1'b0, "en_on");
    repeat (6) @(posedge pClk);
    #1;
    apb_write(ADDR_DIV, 8'd3, 1'b0, "div3");
    cycles_to_tick(4, "div_clear");
    measure_period(4, "period_div3");
    apb_read(ADDR_DIV, 8'd3, 1'b0, "rd_div3");

    // Single frame 0xA5 (four ones -> parity 0)
    sync_tick();
    apb_write(ADDR_DATA, 8'hA5, 1'b0, "wr_a5");
    push_frame({1'b0, 1'b0, 8'hA5, 1'b1});
    apb_read(ADDR_STAT, 8'h01, 1'b0, "stat_full");
    apb_read(ADDR_STAT, 8'h04, 1'b0, "stat_busy");
    wait_ticks(10);
    apb_read(ADDR_STAT, 8'h04, 1'b0, "stat_busy_stop");
    sync_tick();
    apb_read(ADDR_STAT, 8'h00, 1'b0, "stat_tx_done");
    check("irq_tx_masked", 32'(irq), 32'd0);

    // Back-to-back 0x3C, 0xC3; third write refused while holding is full
    sync_tick();
    apb_write(ADDR_DATA, 8'h3C, 1'b0, "wr_3c");
    push_frame({1'b0, 1'b0, 8'h3C, 1'b1});
    push_frame({1'b0, 1'b0, 8'hC3, 1'b1});
    sync_tick();
    apb_write(ADDR_DATA, 8'hC3, 1'b0, "wr_c3");
    apb_write(ADDR_DATA, 8'h11, 1'b1, "wr_refused");
    apb_read(ADDR_STAT, 8'h05, 1'b0, "stat_full_busy");
    wait_ticks(21);
    apb_read(ADDR_STAT, 8'h00, 1'b0, "stat_b2b_done");

    // RX good frame 0x5A (parity 0)
    send_rx({1'b0, 1'b0, 8'h5A, 1'b1});
    apb_read(ADDR_STAT, 8'h02, 1'b0, "stat_rx_valid");
    apb_read(ADDR_DATA, 8'h5A, 1'b0, "rd_5a");
    apb_read(ADDR_STAT, 8'h00, 1'b0, "stat_rx_popped");
    apb_read(ADDR_DATA, 8'h00, 1'b1, "rd_empty");

    // RX errors: bad parity, bad stop, then two good frames -> overrun
    send_rx({1'b0, 1'b1, 8'h5A, 1'b1});
    send_rx({1'b1, 1'b0, 8'h0F, 1'b1});
    send_rx({1'b0, 1'b1, 8'h80, 1'b1});
    send_rx({1'b0, 1'b0, 8'h7E, 1'b1});
    apb_read(ADDR_STAT, 8'h3A, 1'b0, "stat_errs");
    apb_read(ADDR_DATA, 8'h80, 1'b0, "rd_first_good");
    apb_write(ADDR_STAT, 8'h38, 1'b0, "w1c");
    apb_read(ADDR_STAT, 8'h00, 1'b0, "stat_cleared");

    // Disable mid-frame: 0x96 sends start, d0=0, d1=1, then line drops
    sync_tick();
    apb_write(ADDR_DATA, 8'h96, 1'b0, "wr_96");
    tx_q.push_back(1'b1);
    tx_q.push_back(1'b0);
    tx_q.push_back(1'b1);
    wait_ticks(3);
    apb_write(ADDR_CTRL, 8'h00, 1'b0, "en_off");
    check("dis_txd", 32'(txd), 32'd0);
    apb_read(ADDR_STAT, 8'h00, 1'b0, "stat_dis_idle");
    apb_write(ADDR_DATA, 8'h69, 1'b0, "wr_69_pending");
    apb_read(ADDR_STAT, 8'h01, 1'b0, "stat_pending");
    check("irq_dis", 32'(irq), 32'd0);

    // Re-enable with both irq enables: pending 0x69 goes out from its start bit
    apb_write(ADDR_CTRL, 8'h07, 1'b0, "en_irq");
    push_frame({1'b0, 1'b0, 8'h69, 1'b1});
    check("irq_full", 32'(irq), 32'd0);
    sync_tick();
    check("irq_empty", 32'(irq), 32'd1);
    apb_read(ADDR_STAT, 8'h04, 1'b0, "stat_reen_busy");
    wait_ticks(11);
    apb_read(ADDR_STAT, 8'h00, 1'b0, "stat_reen_done");
    apb_write(ADDR_CTRL, 8'h05, 1'b0, "irq_rx_only");
    check("irq_rx_none", 32'(irq), 32'd0);
    send_rx({1'b0, 1'b0, 8'h3C, 1'b1});
    check("irq_rx_valid", 32'(irq), 32'd1);
    apb_read(ADDR_DATA, 8'h3C, 1'b0, "rd_3c");
    check("irq_rx_cleared", 32'(irq), 32'd0);

    // DIV = 0: tick on every enabled cycle
    apb_write(ADDR_DIV, 8'd0, 1'b0, "div0");
    measure_period(1, "period_div0");
    apb_write(ADDR_DIV, 8'd3, 1'b0, "div3_again");
    measure_period(4, "period_div3_again");

    // Reset in the middle of a frame
    sync_tick();
    apb_write(ADDR_DATA, 8'hFF, 1'b0, "wr_ff");
    tx_q.push_back(1'b1);
    sync_tick();
    @(posedge pClk); #1 rst = 1'b1;
    @(posedge pClk); #1 rst = 1'b0;
    check("rst2_txd", 32'(txd), 32'd0);
    check("rst2_irq", 32'(irq), 32'd0);
    apb_read(ADDR_STAT, 8'h00, 1'b0, "rst2_stat");
    apb_read(ADDR_CTRL, 8'h00, 1'b0, "rst2_ctrl");
    apb_read(ADDR_DIV,  8'd79, 1'b0, "rst2_div");
    apb_read(ADDR_DATA, 8'h00, 1'b1, "rst2_data");

    repeat (4) @(posedge pClk);
    check("apb_q_drained", 32'(apb_q.size()), 32'd0);
    check("tx_q_drained", 32'(tx_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic measure_period(input int exp, input string name);
    sync_tick();
    cycles_to_tick(exp, name);
  endtask

endmodule
